// File: rtl/ldl_rr_dispatch_if.sv
// ldl_rr_dispatch_if: granted input stream (bin/cos/user with valid/ready)
// feeding the round-robin dispatcher.
interface ldl_rr_dispatch_if #(
  parameter int BIN_WIDTH  = 3,
  parameter int COS_WIDTH  = 2,
  parameter int USER_WIDTH = 1
);
  logic                  valid;
  logic                  ready;
  logic [BIN_WIDTH-1:0]  bin;
  logic [COS_WIDTH-1:0]  icos;
  logic [USER_WIDTH-1:0] iuser;

  modport master (
    output valid,
    output bin,
    output icos,
    output iuser,
    input  ready
  );

  modport slave (
    input  valid,
    input  bin,
    input  icos,
    input  iuser,
    output ready
  );
endinterface

// File: rtl/ldl_rr_dispatch.sv
// ldl_rr_dispatch: routes each input beat to a per-channel FIFO chosen by bin.
// Optional LDL_RR_DISPATCH_STALL_CNT_EN adds per-channel stall counters.
module ldl_rr_dispatch #(
  parameter int BIN_WIDTH   = 3,
  parameter int COS_WIDTH   = 2,
  parameter int USER_WIDTH  = 1,
  parameter int REQ_WIDTH   = 1 << BIN_WIDTH,
  parameter int DEPTH_WIDTH = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  ldl_rr_dispatch_if.slave                      in_if,
  output logic [REQ_WIDTH-1:0]                  req,
  input  logic [REQ_WIDTH-1:0]                  ack,
  output logic [REQ_WIDTH-1:0][COS_WIDTH-1:0]   ocos,
  output logic [REQ_WIDTH-1:0][USER_WIDTH-1:0]  ouser,
  output logic [REQ_WIDTH-1:0][DEPTH_WIDTH:0]   level
`ifdef LDL_RR_DISPATCH_STALL_CNT_EN
  ,
  output logic [REQ_WIDTH-1:0][15:0]            stall_cnt
`endif
);

  localparam int D  = 1 << DEPTH_WIDTH;
  localparam int EW = COS_WIDTH + USER_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};

  logic [REQ_WIDTH-1:0] full_vec;
  logic                 push;

  // Space check ignores same-cycle ack so ready never depends on consumers.
  assign in_if.ready = !full_vec[in_if.bin];
  assign push        = in_if.valid && in_if.ready;

  for (genvar i = 0; i < REQ_WIDTH; i++) begin : g_ch
    logic [EW-1:0]          mem [D];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   cnt;
    logic                   sel;
    logic                   push_i;
    logic                   pop_i;
    logic [EW-1:0]          head;

    assign sel    = (in_if.bin == BIN_WIDTH'(i));
    assign push_i = push && sel;
    assign pop_i  = req[i] && ack[i];
    assign head   = mem[rd_ptr];

    assign full_vec[i] = (cnt == FULL);
    assign req[i]      = (cnt != '0);
    assign level[i]    = cnt;
    assign ocos[i]     = req[i] ? head[EW-1:USER_WIDTH] : '0;
    assign ouser[i]    = req[i] ? head[USER_WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
      if (push_i) begin
        mem[wr_ptr] <= {in_if.icos, in_if.iuser};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push_i) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop_i) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        unique case ({push_i, pop_i})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

`ifdef LDL_RR_DISPATCH_STALL_CNT_EN
    logic [15:0] sc;

    always_ff @(posedge clk) begin
      if (rst) begin
        sc <= '0;
      end else if (in_if.valid && !in_if.ready && sel
                   && sc != 16'hFFFF) begin
        sc <= sc + 16'd1;
      end
    end

    assign stall_cnt[i] = sc;
`endif
  end

endmodule
